// File: rtl/qea_host_pkg.sv
// qea_host_pkg: shared FSM state encoding and state-vector beat-count helper for the QEA host loader
package qea_host_pkg;

    typedef logic [2:0] qh_state_t;

    localparam qh_state_t S_IDLE    = 3'd0;
    localparam qh_state_t S_LD_CTX  = 3'd1;
    localparam qh_state_t S_LD_ST   = 3'd2;
    localparam qh_state_t S_START   = 3'd3;
    localparam qh_state_t S_RUN     = 3'd4;
    localparam qh_state_t S_RD_REQ  = 3'd5;
    localparam qh_state_t S_RD_WAIT = 3'd6;
    localparam qh_state_t S_RD_OUT  = 3'd7;

    // Index of the last state word: NST-1, where NST = 2**(qbit_num-pe_w) or 1 for tiny runs.
    function automatic logic [31:0] nst_last_idx(input logic [31:0] qbit_num, input logic [31:0] pe_w);
        return (qbit_num <= pe_w) ? 32'd0 : ((32'd1 << (qbit_num - pe_w)) - 32'd1);
    endfunction

endpackage

// File: rtl/qea_host_loader.sv
// qea_host_loader: loads context and initial state into QEA, starts it, times the run and drains the final state
module qea_host_loader
    import qea_host_pkg::*;
#(
    parameter int PE_NUM_WIDTH            = 2,
    parameter int PE_NUM                  = 4,
    parameter int STATE_DATA_WIDTH        = 64,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_CONTEXT_DATA_WIDTH = 64,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int MAX_QBIT_WIDTH          = 6,
    parameter int RD_LAT                  = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_cfg_valid,
    output logic                                 o_cfg_ready,
    input  logic [MAX_QBIT_WIDTH-1:0]            i_cfg_qbit_num,
    input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_cfg_ctx_num,
    input  logic                                 s_ctx_valid,
    output logic                                 s_ctx_ready,
    input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   s_ctx_data,
    input  logic                                 s_st_valid,
    output logic                                 s_st_ready,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   s_st_data,
    output logic                                 m_st_valid,
    input  logic                                 m_st_ready,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   m_st_data,
    output logic                                 m_st_last,
    output logic                                 o_qea_start,
    output logic [MAX_QBIT_WIDTH-1:0]            o_qea_qbit_num,
    output logic                                 o_ctx_en,
    output logic                                 o_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
    output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
    output logic                                 o_state_ena,
    output logic                                 o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
    input  logic                                 i_qea_complete,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_qea_state_dout,
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic [31:0]                          o_run_cycles
);

    localparam int SW = PE_NUM * STATE_DATA_WIDTH;
    localparam int CA = GATE_CONTEXT_ADDR_WIDTH;
    localparam int SA = STATE_ADDR_WIDTH;
    localparam logic [CA-1:0] CTX_ONE  = {{(CA-1){1'b0}}, 1'b1};
    localparam logic [SA-1:0] ST_ONE   = {{(SA-1){1'b0}}, 1'b1};
    localparam logic [7:0]    LAT_LAST = 8'(RD_LAT - 1);

    qh_state_t                        r_state;
    logic [MAX_QBIT_WIDTH-1:0]        r_qbit;
    logic [CA-1:0]                    r_ctx_num;
    logic [CA-1:0]                    r_ctx_idx;
    logic [SA-1:0]                    r_st_idx;
    logic [SA-1:0]                    r_rd_idx;
    logic                             r_ctx_en;
    logic [CA-1:0]                    r_ctx_addr;
    logic [GATE_CONTEXT_DATA_WIDTH-1:0] r_ctx_data;
    logic                             r_st_we;
    logic [SA-1:0]                    r_st_waddr;
    logic [SW-1:0]                    r_st_wdata;
    logic [31:0]                      r_run_cnt;
    logic [31:0]                      r_run_cycles;
    logic                             r_first;
    logic [7:0]                       r_lat;
    logic [SW-1:0]                    r_m_data;
    logic                             r_done;

    logic                             w_cfg_fire;
    logic                             w_ctx_fire;
    logic                             w_st_fire;
    logic                             w_m_fire;
    logic                             w_rd_req;
    logic [31:0]                      w_nst_last;
    logic                             w_ctx_last;
    logic                             w_st_last;
    logic                             w_rd_last;

    // Config is refused in the cycle that o_done pulses, so a back-to-back cfg waits one cycle.
    assign o_cfg_ready    = (r_state == S_IDLE) & ~r_done;
    assign o_busy         = r_state != S_IDLE;
    assign s_ctx_ready    = r_state == S_LD_CTX;
    assign s_st_ready     = r_state == S_LD_ST;
    assign o_qea_start    = r_state == S_START;
    assign m_st_valid     = r_state == S_RD_OUT;
    assign m_st_data      = r_m_data;
    assign m_st_last      = m_st_valid & w_rd_last;
    assign o_qea_qbit_num = r_qbit;
    assign o_ctx_en       = r_ctx_en;
    assign o_ctx_wea      = r_ctx_en;
    assign o_ctx_addr     = r_ctx_addr;
    assign o_ctx_data     = r_ctx_data;
    assign o_done         = r_done;
    assign o_run_cycles   = r_run_cycles;

    assign w_cfg_fire = i_cfg_valid & o_cfg_ready;
    assign w_ctx_fire = s_ctx_valid & s_ctx_ready;
    assign w_st_fire  = s_st_valid & s_st_ready;
    assign w_m_fire   = m_st_valid & m_st_ready;
    assign w_rd_req   = r_state == S_RD_REQ;
    assign w_nst_last = nst_last_idx(32'(r_qbit), 32'(PE_NUM_WIDTH));
    assign w_ctx_last = r_ctx_idx == (r_ctx_num - CTX_ONE);
    assign w_st_last  = 32'(r_st_idx) == w_nst_last;
    assign w_rd_last  = 32'(r_rd_idx) == w_nst_last;

    // The state port is shared: loader writes never overlap a readback request.
    assign o_state_ena   = r_st_we | w_rd_req;
    assign o_state_wea   = r_st_we;
    assign o_state_addra = w_rd_req ? r_rd_idx : r_st_waddr;
    assign o_state_dina  = r_st_wdata;

    // Main sequencer: config, load, start, timed run, then one-at-a-time readback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_qbit       <= '0;
            r_ctx_num    <= '0;
            r_ctx_idx    <= '0;
            r_st_idx     <= '0;
            r_rd_idx     <= '0;
            r_run_cnt    <= '0;
            r_run_cycles <= '0;
            r_first      <= 1'b0;
            r_lat        <= '0;
            r_m_data     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cfg_fire) begin
                        r_qbit    <= i_cfg_qbit_num;
                        r_ctx_num <= i_cfg_ctx_num;
                        r_ctx_idx <= '0;
                        r_st_idx  <= '0;
                        r_rd_idx  <= '0;
                        r_state   <= (i_cfg_ctx_num == '0) ? S_LD_ST : S_LD_CTX;
                    end
                end
                S_LD_CTX: begin
                    if (w_ctx_fire) begin
                        r_ctx_idx <= r_ctx_idx + CTX_ONE;
                        if (w_ctx_last) r_state <= S_LD_ST;
                    end
                end
                S_LD_ST: begin
                    if (w_st_fire) begin
                        r_st_idx <= r_st_idx + ST_ONE;
                        if (w_st_last) r_state <= S_START;
                    end
                end
                S_START: begin
                    r_run_cnt <= 32'd1;
                    r_first   <= 1'b1;
                    r_state   <= S_RUN;
                end
                S_RUN: begin
                    r_first <= 1'b0;
                    // The complete flag may still be high from the previous run in the first cycle.
                    if (!r_first && i_qea_complete) begin
                        r_run_cycles <= r_run_cnt;
                        r_state      <= S_RD_REQ;
                    end else begin
                        r_run_cnt <= r_run_cnt + 32'd1;
                    end
                end
                S_RD_REQ: begin
                    r_lat   <= '0;
                    r_state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (r_lat == LAT_LAST) begin
                        r_m_data <= i_qea_state_dout;
                        r_state  <= S_RD_OUT;
                    end else begin
                        r_lat <= r_lat + 8'd1;
                    end
                end
                S_RD_OUT: begin
                    if (w_m_fire) begin
                        if (w_rd_last) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_rd_idx <= r_rd_idx + ST_ONE;
                            r_state  <= S_RD_REQ;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Register each accepted load beat into a one-cycle RAM write at its sequential address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctx_en   <= 1'b0;
            r_ctx_addr <= '0;
            r_ctx_data <= '0;
            r_st_we    <= 1'b0;
            r_st_waddr <= '0;
            r_st_wdata <= '0;
        end else begin
            r_ctx_en <= w_ctx_fire;
            r_st_we  <= w_st_fire;
            if (w_ctx_fire) begin
                r_ctx_addr <= r_ctx_idx;
                r_ctx_data <= s_ctx_data;
            end
            if (w_st_fire) begin
                r_st_waddr <= r_st_idx;
                r_st_wdata <= s_st_data;
            end
        end
    end

    // Done pulses for one cycle after the final readback beat is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_done <= 1'b0;
        else        r_done <= w_m_fire & w_rd_last;
    end

endmodule

// File: tb/tb_qea_host_loader.sv
// tb_qea_host_loader: directed bench with a small QEA RAM/complete model around qea_host_loader
module tb_qea_host_loader;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_cfg_valid;
    logic         o_cfg_ready;
    logic [5:0]   i_cfg_qbit_num;
    logic [15:0]  i_cfg_ctx_num;
    logic         s_ctx_valid;
    logic         s_ctx_ready;
    logic [63:0]  s_ctx_data;
    logic         s_st_valid;
    logic         s_st_ready;
    logic [255:0] s_st_data;
    logic         m_st_valid;
    logic         m_st_ready;
    logic [255:0] m_st_data;
    logic         m_st_last;
    logic         o_qea_start;
    logic [5:0]   o_qea_qbit_num;
    logic         o_ctx_en;
    logic         o_ctx_wea;
    logic [15:0]  o_ctx_addr;
    logic [63:0]  o_ctx_data;
    logic         o_state_ena;
    logic         o_state_wea;
    logic [15:0]  o_state_addra;
    logic [255:0] o_state_dina;
    logic         qea_complete = 1'b0;
    logic [255:0] qea_dout = '0;
    logic         o_busy;
    logic         o_done;
    logic [31:0]  o_run_cycles;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    qea_host_loader dut (
        .clk(clk), .rst_n(rst_n),
        .i_cfg_valid(i_cfg_valid), .o_cfg_ready(o_cfg_ready),
        .i_cfg_qbit_num(i_cfg_qbit_num), .i_cfg_ctx_num(i_cfg_ctx_num),
        .s_ctx_valid(s_ctx_valid), .s_ctx_ready(s_ctx_ready), .s_ctx_data(s_ctx_data),
        .s_st_valid(s_st_valid), .s_st_ready(s_st_ready), .s_st_data(s_st_data),
        .m_st_valid(m_st_valid), .m_st_ready(m_st_ready), .m_st_data(m_st_data),
        .m_st_last(m_st_last), .o_qea_start(o_qea_start), .o_qea_qbit_num(o_qea_qbit_num),
        .o_ctx_en(o_ctx_en), .o_ctx_wea(o_ctx_wea), .o_ctx_addr(o_ctx_addr), .o_ctx_data(o_ctx_data),
        .o_state_ena(o_state_ena), .o_state_wea(o_state_wea), .o_state_addra(o_state_addra),
        .o_state_dina(o_state_dina), .i_qea_complete(qea_complete), .i_qea_state_dout(qea_dout),
        .o_busy(o_busy), .o_done(o_done), .o_run_cycles(o_run_cycles)
    );

    function automatic logic [63:0] ctx_word(input logic [15:0] k);
        return {16'hC7C7, k, ~k, 16'h5A5A ^ k};
    endfunction

    function automatic logic [255:0] st_word(input logic [15:0] k);
        return (k == 16'd0) ? {64'h4000_0000_0000_0000, 192'd0}
                            : {16'h3333, k, 32'h0, 16'h2222, k, 32'h1, 16'h1111, k, 32'h2, 16'h0000, k, 32'h3};
    endfunction

    // QEA RAM model: checks write/read ordering and serves reads with one cycle latency
    logic [255:0] st_mem [0:63];
    int ctx_idx = 0, st_idx = 0, rd_idx = 0, start_cnt = 0;
    int ctx_bad = 0, st_bad = 0, rd_bad = 0;
    always @(posedge clk) begin
        if (i_cfg_valid && o_cfg_ready) begin
            ctx_idx <= 0; st_idx <= 0; rd_idx <= 0; start_cnt <= 0;
        end else begin
            if (o_qea_start) start_cnt <= start_cnt + 1;
            if (o_ctx_en) begin
                if (!o_ctx_wea || o_ctx_addr != 16'(ctx_idx) || o_ctx_data != ctx_word(16'(ctx_idx))) ctx_bad <= ctx_bad + 1;
                ctx_idx <= ctx_idx + 1;
            end
            if (o_state_ena && o_state_wea) begin
                if (o_state_addra != 16'(st_idx) || o_state_dina != st_word(16'(st_idx))) st_bad <= st_bad + 1;
                st_mem[o_state_addra[5:0]] <= o_state_dina;
                st_idx <= st_idx + 1;
            end
            if (o_state_ena && !o_state_wea) begin
                if (o_state_addra != 16'(rd_idx)) rd_bad <= rd_bad + 1;
                qea_dout <= st_mem[o_state_addra[5:0]];
                rd_idx <= rd_idx + 1;
            end
        end
    end

    // QEA completion model: complete rises q_delay cycles after the start edge and stays high
    int q_cnt = 0;
    int q_delay = 50;
    bit q_active = 1'b0;
    bit stale = 1'b0;
    always @(posedge clk) begin
        if (o_qea_start) begin
            q_cnt <= 1; q_active <= 1'b1;
            if (!stale) qea_complete <= 1'b0;
        end else begin
            if (q_active) q_cnt <= q_cnt + 1;
            if (stale && q_active && q_cnt == 1) qea_complete <= 1'b0;
            if (q_active && q_cnt == q_delay) begin qea_complete <= 1'b1; q_active <= 1'b0; end
        end
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_ctrl"}, {o_cfg_ready, s_ctx_ready, s_st_ready, m_st_valid, m_st_last, o_qea_start,
                               o_ctx_en, o_ctx_wea, o_state_ena, o_state_wea, o_busy, o_done}, 256'h800);
        check({tag, "_addr"}, {o_ctx_addr, o_state_addra, o_qea_qbit_num}, 256'd0);
        check({tag, "_run_cycles"}, o_run_cycles, 256'd0);
        check({tag, "_data"}, m_st_data | o_state_dina | {192'd0, o_ctx_data}, 256'd0);
    endtask

    task automatic do_cfg(input int q, input int c);
        check("cfg_ready_idle", o_cfg_ready, 1);
        i_cfg_qbit_num = 6'(q); i_cfg_ctx_num = 16'(c); i_cfg_valid = 1'b1;
        step();
        i_cfg_valid = 1'b0;
        check("busy_after_cfg", o_busy, 1);
        check("qbit_out", o_qea_qbit_num, 256'(q));
    endtask

    task automatic feed_ctx(input int n, input bit gap);
        int k = 0, t = 0;
        bit hs;
        while (k < n && t < 20000) begin
            s_ctx_valid = gap ? 1'($urandom_range(0, 1)) : 1'b1;
            s_ctx_data = ctx_word(16'(k));
            hs = s_ctx_valid && s_ctx_ready;
            step(); t++;
            if (hs) k++;
        end
        s_ctx_valid = 1'b0;
        check("ctx_beats_accepted", 256'(k), 256'(n));
    endtask

    task automatic feed_st(input int n, input bit gap);
        int k = 0, t = 0;
        bit hs;
        while (k < n && t < 20000) begin
            s_st_valid = gap ? 1'($urandom_range(0, 1)) : 1'b1;
            s_st_data = st_word(16'(k));
            hs = s_st_valid && s_st_ready;
            step(); t++;
            if (hs) k++;
        end
        s_st_valid = 1'b0;
        check("st_beats_accepted", 256'(k), 256'(n));
    endtask

    task automatic wait_start();
        int t = 0;
        while (!o_qea_start && t < 100) begin step(); t++; end
        check("start_seen", o_qea_start, 1);
        step();
        check("start_one_cycle", o_qea_start, 0);
    endtask

    task automatic drain(input int n, input int stall_at, input int exp_cyc);
        int t, bad;
        logic [255:0] d0;
        for (int j = 0; j < n; j++) begin
            t = 0;
            while (!m_st_valid && t < 500) begin step(); t++; end
            check("mst_data", m_st_data, st_word(16'(j)));
            check("mst_last", m_st_last, 256'(j == n - 1));
            if (j == stall_at) begin
                m_st_ready = 1'b0;
                d0 = m_st_data;
                bad = 0;
                repeat (20) begin
                    step();
                    if (!m_st_valid || m_st_data !== d0) bad++;
                end
                check("stall_stable", 256'(bad), 256'd0);
                m_st_ready = 1'b1;
            end
            step();
        end
        check("done_pulse", {o_done, o_cfg_ready}, 256'b10);
        step();
        check("done_clear", {o_done, o_cfg_ready, o_busy}, 256'b010);
        check("run_cycles", o_run_cycles, 256'(exp_cyc));
    endtask

    task automatic run(input int q, input int c, input bit gap, input int qd, input bit stl, input int stall_at);
        int nst;
        nst = (q <= 2) ? 1 : (1 << (q - 2));
        q_delay = qd; stale = stl;
        do_cfg(q, c);
        feed_ctx(c, gap);
        feed_st(nst, gap);
        wait_start();
        drain(nst, stall_at, qd + 1);
        check("ctx_writes", 256'(ctx_idx), 256'(c));
        check("st_writes", 256'(st_idx), 256'(nst));
        check("st_reads", 256'(rd_idx), 256'(nst));
        check("start_count", 256'(start_cnt), 256'd1);
        check("order_errors", {ctx_bad[31:0], st_bad[31:0], rd_bad[31:0]}, 256'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        i_cfg_valid = 1'b0; i_cfg_qbit_num = '0; i_cfg_ctx_num = '0;
        s_ctx_valid = 1'b0; s_ctx_data = '0;
        s_st_valid = 1'b0; s_st_data = '0;
        m_st_ready = 1'b1;
        repeat (3) step();
        check_reset_outs("reset");
        rst_n = 1'b1;
        step();
        run(7, 397, 1'b0, 50, 1'b0, -1);
        run(6, 40, 1'b1, 20, 1'b0, 5);
        run(2, 3, 1'b0, 10, 1'b1, -1);
        q_delay = 30; stale = 1'b0;
        do_cfg(4, 2);
        feed_ctx(2, 1'b0);
        feed_st(1, 1'b0);
        #3 rst_n = 1'b0;
        #1 check_reset_outs("rst_ld_st");
        step();
        rst_n = 1'b1;
        step();
        do_cfg(2, 1);
        feed_ctx(1, 1'b0);
        feed_st(1, 1'b0);
        wait_start();
        repeat (3) step();
        check("in_run_busy", o_busy, 1);
        #3 rst_n = 1'b0;
        #1 check_reset_outs("rst_run");
        step();
        rst_n = 1'b1;
        step();
        run(3, 0, 1'b0, 5, 1'b0, -1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
